// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage and its address unit.
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned MEM_DEPTH_DEF = 64;
  localparam int unsigned RD_W_DEF      = 4;

  typedef enum logic [1:0] {
    OP_PASS    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Execute-side, data-memory-side and writeback-side signals of the memory-access stage.
interface mem_access_stage_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_base;
  logic [7:0]        in_offset;
  logic [DATA_W-1:0] in_store_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [RD_W-1:0]   in_rd;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic              out_fault;

  modport slave (
    input  in_valid, in_op, in_base, in_offset, in_store_data, in_alu_result, in_rd,
    output in_ready,
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata,
    output out_valid, out_data, out_rd, out_reg_write, out_fault,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_base, in_offset, in_store_data, in_alu_result, in_rd,
    input  in_ready,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata,
    input  out_valid, out_data, out_rd, out_reg_write, out_fault,
    output out_ready
  );

endinterface

// File: rtl/mem_agu.sv
// Effective-address unit: base plus sign-extended 8-bit offset (mod 2^16) with range check.
module mem_agu
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic [15:0] base,
  input  logic [7:0]  offset,
  input  logic        check_range,
  output logic [15:0] eff,
  output logic        fault
);

  always_comb begin
    eff   = base + {{8{offset[7]}}, offset};
    fault = check_range && (eff >= 16'(MEM_DEPTH));
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: accepts one op, drives the data memory for one ACCESS cycle,
// then holds the response for writeback until it is taken.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned RD_W      = RD_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_access_stage_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              fault_q, fault_d;

  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              out_fault_q, out_fault_d;

  op_e         in_op;
  logic        in_ready;
  logic        accept;
  logic [15:0] eff;
  logic        agu_fault;
  logic        new_fault;

  assign in_op = op_e'(bus.in_op);

  mem_agu #(.MEM_DEPTH(MEM_DEPTH)) u_agu (
    .base        (bus.in_base),
    .offset      (bus.in_offset),
    .check_range ((in_op == OP_LOAD) || (in_op == OP_STORE)),
    .eff         (eff),
    .fault       (agu_fault)
  );

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && bus.out_ready);
    accept    = bus.in_valid && in_ready;
    new_fault = agu_fault || (in_op == OP_ILLEGAL);

    state_d         = state_q;
    op_d            = op_q;
    rd_d            = rd_q;
    alu_d           = alu_q;
    fault_d         = fault_q;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    out_fault_d     = out_fault_q;

    unique case (state_q)
      S_ACCESS: begin
        out_valid_d     = 1'b1;
        out_rd_d        = rd_q;
        out_fault_d     = fault_q;
        out_reg_write_d = !fault_q && ((op_q == OP_LOAD) || (op_q == OP_PASS));
        if (!fault_q && (op_q == OP_LOAD))  out_data_d = bus.mem_rdata;
        else if (op_q == OP_PASS)           out_data_d = alu_q;
        else                                out_data_d = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: ;
    endcase

    // Memory strobes are registered at accept so they are live for exactly the ACCESS cycle.
    if (accept) begin
      state_d     = S_ACCESS;
      op_d        = in_op;
      rd_d        = bus.in_rd;
      alu_d       = bus.in_alu_result;
      fault_d     = new_fault;
      mem_addr_d  = eff[ADDR_W-1:0];
      mem_we_d    = (in_op == OP_STORE) && !new_fault;
      mem_re_d    = (in_op == OP_LOAD) && !new_fault;
      mem_wdata_d = mem_we_d ? bus.in_store_data : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      op_q            <= OP_PASS;
      rd_q            <= '0;
      alu_q           <= '0;
      fault_q         <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_rd_q        <= '0;
      out_reg_write_q <= 1'b0;
      out_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      rd_q            <= rd_d;
      alu_q           <= alu_d;
      fault_q         <= fault_d;
      mem_we_q        <= mem_we_d;
      mem_re_q        <= mem_re_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_fault_q     <= out_fault_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_re        = mem_re_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_reg_write = out_reg_write_q;
  assign bus.out_fault     = out_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural data memory on the bus.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic reset_n;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.DATA_W(16), .ADDR_W(8), .RD_W(4)) bus ();

  mem_access_stage #(
    .DATA_W(16), .ADDR_W(8), .MEM_DEPTH(64), .RD_W(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Unwritten words read as 0xA000 + address.
  bit [15:0] mem_val [256];
  bit        mem_wr  [256];

  assign bus.mem_rdata = !bus.mem_re ? 16'h0000 :
                         mem_wr[bus.mem_addr] ? mem_val[bus.mem_addr] :
                         (16'hA000 + {8'h00, bus.mem_addr});

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_val[bus.mem_addr] <= bus.mem_wdata;
      mem_wr[bus.mem_addr]  <= 1'b1;
    end
  end

  function automatic logic [15:0] mem_peek(input int a);
    return mem_wr[a] ? mem_val[a] : (16'hA000 + 16'(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic        a_we, a_re, r_valid, r_rw, r_fault, r_we, r_re;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata, r_data;
  logic [3:0]  r_rd;

  task automatic drive(input logic [1:0] op, input logic [15:0] base, input logic [7:0] off,
                       input logic [15:0] sd, input logic [15:0] alu, input logic [3:0] rd);
    bus.in_op         = op;
    bus.in_base       = base;
    bus.in_offset     = off;
    bus.in_store_data = sd;
    bus.in_alu_result = alu;
    bus.in_rd         = rd;
    bus.in_valid      = 1'b1;
  endtask

  // Called at a negedge with out_ready=1; returns at the negedge inside RESP.
  task automatic run_op(input logic [1:0] op, input logic [15:0] base, input logic [7:0] off,
                        input logic [15:0] sd, input logic [15:0] alu, input logic [3:0] rd);
    int n = 0;
    drive(op, base, off, sd, alu, rd);
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) check("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    a_we = bus.mem_we; a_re = bus.mem_re; a_addr = bus.mem_addr; a_wdata = bus.mem_wdata;
    @(negedge clk);
    r_valid = bus.out_valid; r_data = bus.out_data; r_rd = bus.out_rd;
    r_rw = bus.out_reg_write; r_fault = bus.out_fault; r_we = bus.mem_we; r_re = bus.mem_re;
  endtask

  localparam logic [15:0] B2B_EXP [8] = '{16'h0100, 16'hA00B, 16'h0102, 16'hA00D,
                                          16'h0104, 16'hA00F, 16'h0106, 16'hA011};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_base = '0; bus.in_offset = '0;
    bus.in_store_data = '0; bus.in_alu_result = '0; bus.in_rd = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_mem_en",    32'({bus.mem_we, bus.mem_re}), 0);
    reset_n = 1'b1;
    check("rst_in_ready",  32'(bus.in_ready), 1);

    // Reset during ACCESS of a STORE to address 5.
    drive(2'b10, 16'h0003, 8'h02, 16'h1234, 16'h0000, 4'h0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_pre_we", 32'(bus.mem_we), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem", 32'({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}), 0);
    check("rst_mid_out", 32'({bus.out_valid, bus.out_data, bus.out_rd, bus.out_reg_write, bus.out_fault}), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mem5_kept", 32'(mem_peek(5)), 'hA005);
    check("rst_in_ready2", 32'(bus.in_ready), 1);

    // STORE 0xBEEF to 3+2.
    run_op(2'b10, 16'h0003, 8'h02, 16'hBEEF, 16'h0000, 4'h9);
    check("st_we",    32'(a_we), 1);
    check("st_re",    32'(a_re), 0);
    check("st_addr",  32'(a_addr), 5);
    check("st_wdata", 32'(a_wdata), 'hBEEF);
    check("st_valid", 32'(r_valid), 1);
    check("st_rw",    32'(r_rw), 0);
    check("st_fault", 32'(r_fault), 0);
    check("st_we_off", 32'(r_we), 0);
    check("st_mem5",  32'(mem_peek(5)), 'hBEEF);

    // LOAD 6 + (-1).
    run_op(2'b01, 16'h0006, 8'hFF, 16'h0000, 16'h0000, 4'h7);
    check("ld_re",    32'(a_re), 1);
    check("ld_we",    32'(a_we), 0);
    check("ld_addr",  32'(a_addr), 5);
    check("ld_valid", 32'(r_valid), 1);
    check("ld_data",  32'(r_data), 'hBEEF);
    check("ld_rd",    32'(r_rd), 7);
    check("ld_rw",    32'(r_rw), 1);
    check("ld_fault", 32'(r_fault), 0);
    check("ld_re_off", 32'(r_re), 0);

    // LOAD 0x40: first out-of-range word.
    run_op(2'b01, 16'h0040, 8'h00, 16'h0000, 16'h5555, 4'h3);
    check("flt_en",    32'({a_we, a_re}), 0);
    check("flt_fault", 32'(r_fault), 1);
    check("flt_data",  32'(r_data), 0);
    check("flt_rw",    32'(r_rw), 0);

    // ILLEGAL op.
    run_op(2'b11, 16'h0001, 8'h00, 16'h7777, 16'h5555, 4'h4);
    check("ill_en",    32'({a_we, a_re}), 0);
    check("ill_fault", 32'(r_fault), 1);
    check("ill_data",  32'(r_data), 0);
    check("ill_rw",    32'(r_rw), 0);

    // 0xFFFF + 2 wraps to 1: in range.
    run_op(2'b01, 16'hFFFF, 8'h02, 16'h0000, 16'h0000, 4'h5);
    check("wrap_re",    32'(a_re), 1);
    check("wrap_addr",  32'(a_addr), 1);
    check("wrap_data",  32'(r_data), 'hA001);
    check("wrap_fault", 32'(r_fault), 0);

    // 0 + (-1) wraps to 0xFFFF: fault.
    run_op(2'b01, 16'h0000, 8'hFF, 16'h0000, 16'h0000, 4'h5);
    check("neg_en",    32'({a_we, a_re}), 0);
    check("neg_fault", 32'(r_fault), 1);

    // PASS: no memory traffic.
    run_op(2'b00, 16'h0050, 8'h00, 16'h0000, 16'h1357, 4'h3);
    check("pass_en",   32'({a_we, a_re}), 0);
    check("pass_data", 32'(r_data), 'h1357);
    check("pass_rw",   32'(r_rw), 1);
    check("pass_rd",   32'(r_rd), 3);

    // Backpressure.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(2'b00, 16'h0000, 8'h00, 16'h0000, 16'h1111, 4'h1);
    @(posedge clk);
    @(negedge clk);
    drive(2'b01, 16'h0006, 8'hFF, 16'h0000, 16'h0000, 4'h2);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      check("bp_valid",    32'(bus.out_valid), 1);
      check("bp_data",     32'(bus.out_data), 'h1111);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_en",       32'({bus.mem_we, bus.mem_re}), 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_re",    32'(bus.mem_re), 1);
    check("bp_next_addr",  32'(bus.mem_addr), 5);
    check("bp_next_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("bp_next_data", 32'(bus.out_data), 'hBEEF);
    check("bp_next_rd",   32'(bus.out_rd), 2);

    // Back-to-back alternating PASS/LOAD, one response every 2 cycles.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 1) ? 2'b01 : 2'b00, 16'(10 + i), 8'h00, 16'h0000, 16'(256 + i), 4'(i));
      if (i > 0) begin
        check("b2b_valid", 32'(bus.out_valid), 1);
        check("b2b_data",  32'(bus.out_data), 32'(B2B_EXP[i-1]));
        check("b2b_rd",    32'(bus.out_rd), 32'(i - 1));
      end
      check("b2b_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_access_nv", 32'(bus.out_valid), 0);
      check("b2b_re",        32'(bus.mem_re), 32'(i % 2));
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("b2b_last_valid", 32'(bus.out_valid), 1);
    check("b2b_last_data",  32'(bus.out_data), 32'(B2B_EXP[7]));
    check("b2b_last_rd",    32'(bus.out_rd), 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
